branch_resolution_unit: RTL

Tracks every conditional branch the fetch stage has issued with a prediction, compares each prediction against the real outcome when the execute stage resolves it, and produces the training update consumed by `branch_history_table`. On a misprediction it raises a one-cycle flush with the corrected PC, then drains the wrong-path window for a fixed number of cycles. It sits between fetch/execute and the history table, downstream of the prediction and upstream of the table's write port.

---
 rtl/branch_pkg.sv | 24 ++
 rtl/branch_fifo.sv | 59 +++++
 rtl/branch_resolution_unit.sv | 132 +++++++++++++
 3 files changed

// File: rtl/branch_pkg.sv
// Shared types for branch resolution: entry layout, FSM states, PC-to-index mapping.
// Purely declarative; no latency or backpressure of its own.
package branch_pkg;

    localparam int BRU_IDX_W = 5;
    localparam int BRU_PC_W  = 32;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } bru_state_e;

    typedef struct packed {
        logic [BRU_IDX_W-1:0] idx;
        logic                 pred_taken;
        logic [BRU_PC_W-1:0]  alt_pc;
    } bru_entry_t;

    // Word-aligned PCs: drop the two byte-offset bits.
    function automatic logic [BRU_IDX_W-1:0] pc_to_idx(input logic [BRU_PC_W-1:0] pc);
        return pc[BRU_IDX_W+1:2];
    endfunction

endpackage

// File: rtl/branch_fifo.sv
// In-order FIFO of predicted branches; head visible combinationally, push-to-pop one cycle.
// Push is ignored when full, pop when empty; clear wins over push and pop.
module branch_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         arst,
    input  logic         push_i,
    input  logic [W-1:0] push_dat_i,
    input  logic         pop_i,
    input  logic         clear_i,
    output logic [W-1:0] head_dat_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] cnt_q;
    logic          do_push, do_pop;

    assign empty_o    = (cnt_q == '0);
    assign full_o     = (cnt_q == CW'(DEPTH));
    assign do_push    = push_i && !full_o && !clear_i;
    assign do_pop     = pop_i && !empty_o && !clear_i;
    assign head_dat_o = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/branch_resolution_unit.sv
// Resolves predicted branches in order, emitting training updates and one-cycle flushes; outputs registered (1 cycle).
// pred_ready drops when the queue is full or while draining the wrong path after a mispredict.
module branch_resolution_unit
    import branch_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int PC_W      = BRU_PC_W,
    parameter int IDX_W     = BRU_IDX_W,
    parameter int FLUSH_LEN = 3
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             pred_valid,
    input  logic [PC_W-1:0]  pred_pc,
    input  logic             pred_taken,
    input  logic [PC_W-1:0]  pred_alt_pc,
    output logic             pred_ready,
    input  logic             res_valid,
    input  logic             res_taken,
    output logic             upd_en,
    output logic [IDX_W-1:0] upd_addr,
    output logic             upd_taken,
    output logic             flush,
    output logic [PC_W-1:0]  redirect_pc,
    output logic [15:0]      branch_cnt,
    output logic [15:0]      mispred_cnt,
    output logic             err_underflow
);

    localparam int DCW = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;

    bru_entry_t       push_ent, head;
    logic             fifo_full, fifo_empty;
    logic             do_pop, do_push, mispredict;
    bru_state_e       state_q, state_d;
    logic [DCW-1:0]   drain_q, drain_d;

    logic             upd_en_q, upd_taken_q, flush_q, err_q;
    logic [IDX_W-1:0] upd_addr_q;
    logic [PC_W-1:0]  redirect_q;
    logic [15:0]      branch_cnt_q, mispred_cnt_q;

    assign pred_ready = (state_q == ST_RUN) && !fifo_full;
    assign do_pop     = res_valid && !fifo_empty;
    assign mispredict = do_pop && (head.pred_taken != res_taken);
    // A branch fetched alongside a mispredicting resolve is on the wrong path.
    assign do_push    = pred_valid && pred_ready && !mispredict;

    always_comb begin
        push_ent            = '0;
        push_ent.idx        = pc_to_idx(pred_pc);
        push_ent.pred_taken = pred_taken;
        push_ent.alt_pc     = pred_alt_pc;
    end

    branch_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(bru_entry_t))
    ) u_fifo (
        .clk        (clk),
        .arst       (arst),
        .push_i     (do_push),
        .push_dat_i (push_ent),
        .pop_i      (do_pop),
        .clear_i    (mispredict),
        .head_dat_o (head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        if (mispredict) begin
            state_d = ST_DRAIN;
            drain_d = DCW'(FLUSH_LEN - 1);
        end else if (state_q == ST_DRAIN) begin
            if (drain_q == '0) begin
                state_d = ST_RUN;
            end else begin
                drain_d = drain_q - DCW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q <= ST_RUN;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
        end
    end

    // upd_addr/upd_taken/redirect_pc hold their last value between events.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            upd_en_q      <= 1'b0;
            upd_addr_q    <= '0;
            upd_taken_q   <= 1'b0;
            flush_q       <= 1'b0;
            redirect_q    <= '0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
            err_q         <= 1'b0;
        end else begin
            upd_en_q <= do_pop;
            flush_q  <= mispredict;
            if (do_pop) begin
                upd_addr_q  <= head.idx;
                upd_taken_q <= res_taken;
                if (branch_cnt_q != 16'hFFFF) branch_cnt_q <= branch_cnt_q + 16'd1;
            end
            if (mispredict) begin
                redirect_q <= head.alt_pc;
                if (mispred_cnt_q != 16'hFFFF) mispred_cnt_q <= mispred_cnt_q + 16'd1;
            end
            if (res_valid && fifo_empty) err_q <= 1'b1;
        end
    end

    assign upd_en        = upd_en_q;
    assign upd_addr      = upd_addr_q;
    assign upd_taken     = upd_taken_q;
    assign flush         = flush_q;
    assign redirect_pc   = redirect_q;
    assign branch_cnt    = branch_cnt_q;
    assign mispred_cnt   = mispred_cnt_q;
    assign err_underflow = err_q;

endmodule
